// File: rtl/pio_program_counter_pkg.sv
// Shared address constants and types for a PIO state machine.
// The state-machine FSM and the instruction memory also use them.
package pio_program_counter_pkg;

    localparam int ADDR_W = 5;
    localparam int PC_W   = ADDR_W;

    typedef logic [ADDR_W-1:0] pc_t;

endpackage

// File: rtl/pio_program_counter.sv
// Instruction-address program counter for one PIO state machine.
// Supports stall, jump, and a wrap window that is set by the wrap_top and wrap_bottom inputs.
module pio_program_counter
    import pio_program_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  pc_t  wrap_top,
    input  pc_t  wrap_bottom,
    input  pc_t  jump,
    input  logic jump_en,
    input  logic pc_en,
    output pc_t  pc
);

    pc_t r_pc;
    pc_t w_pc_next;

    // Priority is stall, then jump, then wrap, then increment. Jump wins even when pc sits at wrap_bottom.
    always_comb begin
        w_pc_next = r_pc;
        if (pc_en) begin
            if (jump_en) begin
                w_pc_next = jump;
            end else if (r_pc == wrap_bottom) begin
                w_pc_next = wrap_top;
            end else begin
                w_pc_next = r_pc + pc_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_pio_program_counter.sv
// Directed bench for pio_program_counter.
// Each expected pc is hand-computed and queued before the clock edge that should produce it.
module tb_pio_program_counter;
    import pio_program_counter_pkg::*;

    logic clk;
    logic rst;
    pc_t  wrap_top;
    pc_t  wrap_bottom;
    pc_t  jump;
    logic jump_en;
    logic pc_en;
    pc_t  pc;

    int checks;
    int errors;
    logic [PC_W-1:0] exp_q[$];

    pio_program_counter dut (
        .clk         (clk),
        .rst         (rst),
        .wrap_top    (wrap_top),
        .wrap_bottom (wrap_bottom),
        .jump        (jump),
        .jump_en     (jump_en),
        .pc_en       (pc_en),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input pc_t obs, input pc_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: pc=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the inputs, queue the expected pc, and check it 1 ns after the next rising edge.
    task automatic drive(input string tag, input logic en, input logic jen,
                         input pc_t jmp, input pc_t exp);
        pc_en   = en;
        jump_en = jen;
        jump    = jmp;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(tag, pc, exp_q.pop_front());
    endtask

    task automatic set_window(input pc_t top, input pc_t bottom);
        wrap_top    = top;
        wrap_bottom = bottom;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_window(5'd0, 5'd31);
        jump = '0; jump_en = 1'b0; pc_en = 1'b0;
        #1;
        check("reset_init", pc, 5'd0);
        @(posedge clk);
        #1;
        check("reset_held", pc, 5'd0);
        rst = 1'b0;

        // Full window: 0..31 then back to 0, 1.
        check("seq_start", pc, 5'd0);
        for (int i = 1; i <= 33; i++) begin
            pc_t e;
            e = pc_t'(i % 32);
            drive("seq", 1'b1, 1'b0, 5'd0, e);
        end
        for (int i = 2; i <= 7; i++) begin
            pc_t e;
            e = pc_t'(i);
            drive("seq_to7", 1'b1, 1'b0, 5'd0, e);
        end

        // Assert asynchronous reset away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", pc, 5'd0);
        @(posedge clk);
        #1;
        check("reset_hold1", pc, 5'd0);
        @(posedge clk);
        #1;
        check("reset_hold2", pc, 5'd0);
        rst = 1'b0;

        // Wrap window 4..6, starting from pc 0.
        set_window(5'd4, 5'd6);
        drive("win", 1'b1, 1'b0, 5'd0, 5'd1);
        drive("win", 1'b1, 1'b0, 5'd0, 5'd2);
        drive("win", 1'b1, 1'b0, 5'd0, 5'd3);
        drive("win", 1'b1, 1'b0, 5'd0, 5'd4);
        drive("win", 1'b1, 1'b0, 5'd0, 5'd5);
        drive("win", 1'b1, 1'b0, 5'd0, 5'd6);
        drive("win_wrap", 1'b1, 1'b0, 5'd0, 5'd4);
        drive("win", 1'b1, 1'b0, 5'd0, 5'd5);
        drive("win", 1'b1, 1'b0, 5'd0, 5'd6);
        drive("win_wrap", 1'b1, 1'b0, 5'd0, 5'd4);

        // Stall ignores jump_en.
        drive("jmp_to3", 1'b1, 1'b1, 5'd3, 5'd3);
        drive("stall", 1'b0, 1'b1, 5'd20, 5'd3);
        drive("stall", 1'b0, 1'b1, 5'd20, 5'd3);
        drive("stall", 1'b0, 1'b1, 5'd20, 5'd3);
        drive("stall_rel", 1'b1, 1'b0, 5'd20, 5'd4);

        // Plain jump and the increment that follows it.
        drive("jmp_to2", 1'b1, 1'b1, 5'd2, 5'd2);
        drive("jmp17", 1'b1, 1'b1, 5'd17, 5'd17);
        drive("after_jmp", 1'b1, 1'b0, 5'd17, 5'd18);

        // A jump beats the wrap at wrap_bottom. Without a jump, pc wraps.
        drive("jmp_to6", 1'b1, 1'b1, 5'd6, 5'd6);
        drive("jmp_beats_wrap", 1'b1, 1'b1, 5'd10, 5'd10);
        drive("jmp_to6b", 1'b1, 1'b1, 5'd6, 5'd6);
        drive("wrap_at_bottom", 1'b1, 1'b0, 5'd0, 5'd4);

        // Outside the window, pc rolls over 31 -> 0.
        drive("jmp30", 1'b1, 1'b1, 5'd30, 5'd30);
        drive("oow", 1'b1, 1'b0, 5'd0, 5'd31);
        drive("oow_roll", 1'b1, 1'b0, 5'd0, 5'd0);
        drive("oow", 1'b1, 1'b0, 5'd0, 5'd1);

        // Single-instruction loop when wrap_top == wrap_bottom.
        set_window(5'd9, 5'd9);
        drive("jmp9", 1'b1, 1'b1, 5'd9, 5'd9);
        drive("single_loop", 1'b1, 1'b0, 5'd0, 5'd9);
        drive("single_loop", 1'b1, 1'b0, 5'd0, 5'd9);

        // Inverted window: wrap_top > wrap_bottom.
        set_window(5'd20, 5'd8);
        drive("jmp7", 1'b1, 1'b1, 5'd7, 5'd7);
        drive("inv_win", 1'b1, 1'b0, 5'd0, 5'd8);
        drive("inv_wrap", 1'b1, 1'b0, 5'd0, 5'd20);
        drive("inv_win", 1'b1, 1'b0, 5'd0, 5'd21);

        // A jump to the current pc keeps it in place.
        drive("self_jump", 1'b1, 1'b1, 5'd21, 5'd21);
        drive("self_jump", 1'b1, 1'b1, 5'd21, 5'd21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
